// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker FSM states and the XAPP_052 tap table
// indexed by LFSR width.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // pos[0] is the leftmost tap of the XNOR chain; cnt of 0 marks an unsupported width
  typedef struct packed {
    logic [2:0]      cnt;
    logic [3:0][7:0] pos;
  } lfsr_taps_t;

  function automatic lfsr_taps_t taps2(input logic [7:0] a, input logic [7:0] b);
    lfsr_taps_t t;
    t.cnt = 3'd2;
    t.pos = {8'd0, 8'd0, b, a};
    return t;
  endfunction

  function automatic lfsr_taps_t taps4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    lfsr_taps_t t;
    t.cnt = 3'd4;
    t.pos = {d, c, b, a};
    return t;
  endfunction

  function automatic lfsr_taps_t lfsr_taps(input int unsigned dw);
    lfsr_taps_t t;
    t = '0;
    case (dw)
      3:   t = taps2(8'd3, 8'd2);
      4:   t = taps2(8'd4, 8'd3);
      5:   t = taps2(8'd5, 8'd3);
      6:   t = taps2(8'd6, 8'd5);
      7:   t = taps2(8'd7, 8'd6);
      8:   t = taps4(8'd8, 8'd6, 8'd5, 8'd4);
      9:   t = taps2(8'd9, 8'd5);
      10:  t = taps2(8'd10, 8'd7);
      11:  t = taps2(8'd11, 8'd9);
      12:  t = taps4(8'd12, 8'd6, 8'd4, 8'd1);
      13:  t = taps4(8'd13, 8'd4, 8'd3, 8'd1);
      14:  t = taps4(8'd14, 8'd5, 8'd3, 8'd1);
      15:  t = taps2(8'd15, 8'd14);
      16:  t = taps4(8'd16, 8'd15, 8'd13, 8'd4);
      17:  t = taps2(8'd17, 8'd14);
      18:  t = taps2(8'd18, 8'd11);
      19:  t = taps4(8'd19, 8'd6, 8'd2, 8'd1);
      20:  t = taps2(8'd20, 8'd17);
      21:  t = taps2(8'd21, 8'd19);
      22:  t = taps2(8'd22, 8'd21);
      23:  t = taps2(8'd23, 8'd18);
      24:  t = taps4(8'd24, 8'd23, 8'd22, 8'd17);
      25:  t = taps2(8'd25, 8'd22);
      26:  t = taps4(8'd26, 8'd6, 8'd2, 8'd1);
      27:  t = taps4(8'd27, 8'd5, 8'd2, 8'd1);
      28:  t = taps2(8'd28, 8'd25);
      29:  t = taps2(8'd29, 8'd27);
      30:  t = taps4(8'd30, 8'd6, 8'd4, 8'd1);
      31:  t = taps2(8'd31, 8'd28);
      32:  t = taps4(8'd32, 8'd22, 8'd2, 8'd1);
      33:  t = taps2(8'd33, 8'd20);
      34:  t = taps4(8'd34, 8'd27, 8'd2, 8'd1);
      35:  t = taps2(8'd35, 8'd33);
      128: t = taps4(8'd128, 8'd126, 8'd101, 8'd99);
      168: t = taps4(8'd168, 8'd166, 8'd153, 8'd151);
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Received-word stream and status/counter outputs of the LFSR checker.
interface lfsr_checker_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 32
);
  logic             i_valid;
  logic [DW-1:0]    i_data;
  logic             i_clr;
  logic             o_locked;
  logic             o_err;
  logic [CNT_W-1:0] o_err_cnt;
  logic [CNT_W-1:0] o_word_cnt;

  modport master (
    output i_valid, i_data, i_clr,
    input  o_locked, o_err, o_err_cnt, o_word_cnt
  );

  modport slave (
    input  i_valid, i_data, i_clr,
    output o_locked, o_err, o_err_cnt, o_word_cnt
  );
endinterface

// File: rtl/lfsr_next.sv
// One shift step of an XNOR-feedback Fibonacci LFSR; shared by generator
// and checker so both sides always agree on the sequence.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] word,
  output logic [DW-1:0] next_word
);

  localparam lfsr_taps_t TAPS = lfsr_taps(DW);
  localparam int unsigned I0 = (TAPS.pos[0] == 8'd0) ? 0 : int'(TAPS.pos[0]) - 1;
  localparam int unsigned I1 = (TAPS.pos[1] == 8'd0) ? 0 : int'(TAPS.pos[1]) - 1;
  localparam int unsigned I2 = (TAPS.pos[2] == 8'd0) ? 0 : int'(TAPS.pos[2]) - 1;
  localparam int unsigned I3 = (TAPS.pos[3] == 8'd0) ? 0 : int'(TAPS.pos[3]) - 1;

  if (TAPS.cnt == 3'd0) begin : g_bad_dw
    $error("lfsr_next: unsupported DW");
  end

  logic fb;

  always_comb begin
    fb = word[I0];
    if (TAPS.cnt > 3'd1) fb = fb ~^ word[I1];
    if (TAPS.cnt > 3'd2) fb = fb ~^ word[I2];
    if (TAPS.cnt > 3'd3) fb = fb ~^ word[I3];
    next_word = {word[DW-2:0], fb};
  end

endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker: hunts for a seed, verifies LOCK_CNT predicted words,
// then counts words and errors while locked, free-running its own model.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic           i_sysclk,
  input  logic           i_areset,
  lfsr_checker_if.slave  bus
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);

  lfsr_state_e      state;
  logic [DW-1:0]    model;
  logic [DW-1:0]    pred;
  logic [MW-1:0]    match_cnt;
  logic [UW-1:0]    miss_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic             hit;

  lfsr_next #(.DW(DW)) u_next (
    .word      (model),
    .next_word (pred)
  );

  assign hit = (bus.i_data == pred);

  always_ff @(posedge i_sysclk or posedge i_areset) begin
    if (i_areset) begin
      state     <= HUNT;
      model     <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (bus.i_valid) begin
        case (state)
          HUNT: begin
            // all-ones is the XNOR lockup word and can never seed a sequence
            if (bus.i_data != '1) begin
              model     <= bus.i_data;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              model <= bus.i_data;
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            model <= pred;
            if (!hit) begin
              err <= 1'b1;
              if (miss_cnt == UW'(UNLOCK_CNT - 1)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end

      if (bus.i_clr) begin
        err_cnt  <= '0;
        word_cnt <= '0;
      end else if (bus.i_valid && state == LOCKED) begin
        if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
        if (!hit && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign bus.o_locked   = locked;
  assign bus.o_err      = err;
  assign bus.o_err_cnt  = err_cnt;
  assign bus.o_word_cnt = word_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus a randomized
// stream compared against a word-level behavioural model.
module tb_lfsr_checker;

  localparam int LOCK = 8;
  localparam int UNL  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_checker_if #(.DW(8), .CNT_W(32)) bus ();
  lfsr_checker_if #(.DW(8), .CNT_W(4))  bus4 ();

  lfsr_checker #(.DW(8), .LOCK_CNT(8), .UNLOCK_CNT(4), .CNT_W(32)) dut (
    .i_sysclk (clk),
    .i_areset (rst),
    .bus      (bus)
  );

  lfsr_checker #(.DW(8), .LOCK_CNT(8), .UNLOCK_CNT(4), .CNT_W(4)) dut4 (
    .i_sysclk (clk),
    .i_areset (rst),
    .bus      (bus4)
  );

  int passed = 0;
  int total  = 0;

  // behavioural model state
  bit          m_locked;
  int          m_chain;
  int          m_miss;
  logic [7:0]  m_last;
  bit          m_err;
  logic [31:0] m_errc;
  logic [31:0] m_word;
  logic [7:0]  gen;

  // taps 8,6,5,4 as a mask; an even-length XNOR chain equals inverted parity
  function automatic logic [7:0] ref_next(input logic [7:0] w);
    return {w[6:0], ~^(w & 8'hB8)};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_chain = 0; m_miss = 0; m_last = '0;
    m_err = 0; m_errc = '0; m_word = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    logic [7:0] p;
    m_err = 0;
    if (v) begin
      if (m_locked) begin
        p = ref_next(m_last);
        m_last = p;
        if (m_word != '1) m_word++;
        if (d !== p) begin
          m_err = 1;
          if (m_errc != '1) m_errc++;
          m_miss++;
          if (m_miss == UNL) begin m_locked = 0; m_chain = 0; m_miss = 0; end
        end else m_miss = 0;
      end else if (m_chain == 0) begin
        if (d != 8'hFF) begin m_last = d; m_chain = 1; end
      end else if (d == ref_next(m_last)) begin
        m_last = d;
        m_chain++;
        if (m_chain == LOCK + 1) begin m_locked = 1; m_chain = 0; m_miss = 0; end
      end else m_chain = 0;
    end
    if (c) begin m_errc = '0; m_word = '0; end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    bus.i_valid = v; bus.i_data = d; bus.i_clr = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    bus.i_valid = 1'b0; bus.i_clr = 1'b0;
  endtask

  task automatic cyc4(input logic v, input logic [7:0] d);
    bus4.i_valid = v; bus4.i_data = d; bus4.i_clr = 1'b0;
    @(posedge clk);
    #1;
    bus4.i_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 0; bus.i_data = '0; bus.i_clr = 0;
    bus4.i_valid = 0; bus4.i_data = '0; bus4.i_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (bus.o_locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", bus.o_locked); else passed++;
    total++; if (bus.o_err !== 1'b0) $display("FAIL reset_err got %0b want 0", bus.o_err); else passed++;
    total++; if (bus.o_err_cnt !== 32'd0) $display("FAIL reset_err_cnt got %0d want 0", bus.o_err_cnt); else passed++;
    total++; if (bus.o_word_cnt !== 32'd0) $display("FAIL reset_word_cnt got %0d want 0", bus.o_word_cnt); else passed++;
  endtask

  // feeds n clean words from gen and checks lock appears exactly at word n
  task automatic test_lock_at(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      cyc(1'b1, gen, 1'b0);
      gen = ref_next(gen);
      if (k == n - 1) begin
        total++; if (bus.o_locked !== 1'b0) $display("FAIL %s early_lock got %0b want 0", tag, bus.o_locked); else passed++;
      end
    end
    total++; if (bus.o_locked !== 1'b1) $display("FAIL %s lock got %0b want 1", tag, bus.o_locked); else passed++;
  endtask

  task automatic test_lock();
    gen = 8'h01;
    test_lock_at("lock", 9);
    total++; if (bus.o_err_cnt !== 32'd0) $display("FAIL lock_err_cnt got %0d want 0", bus.o_err_cnt); else passed++;
    total++; if (bus.o_word_cnt !== 32'd0) $display("FAIL lock_word_cnt got %0d want 0", bus.o_word_cnt); else passed++;
  endtask

  task automatic test_single_error();
    cyc(1'b1, gen ^ 8'h01, 1'b0);
    gen = ref_next(gen);
    total++; if (bus.o_err !== 1'b1) $display("FAIL single_err_pulse got %0b want 1", bus.o_err); else passed++;
    total++; if (bus.o_err_cnt !== 32'd1) $display("FAIL single_err_cnt got %0d want 1", bus.o_err_cnt); else passed++;
    total++; if (bus.o_locked !== 1'b1) $display("FAIL single_locked got %0b want 1", bus.o_locked); else passed++;
    cyc(1'b0, 8'h00, 1'b0);
    total++; if (bus.o_err !== 1'b0) $display("FAIL single_err_one_cycle got %0b want 0", bus.o_err); else passed++;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, gen, 1'b0);
      gen = ref_next(gen);
      total++; if (bus.o_err !== 1'b0) $display("FAIL single_followup_err got %0b want 0", bus.o_err); else passed++;
    end
    total++; if (bus.o_err_cnt !== 32'd1) $display("FAIL single_err_cnt_after got %0d want 1", bus.o_err_cnt); else passed++;
    total++; if (bus.o_word_cnt !== 32'd6) $display("FAIL single_word_cnt got %0d want 6", bus.o_word_cnt); else passed++;
  endtask

  task automatic test_unlock();
    cyc(1'b0, 8'h00, 1'b1);
    total++; if (bus.o_err_cnt !== 32'd0) $display("FAIL clr_err_cnt got %0d want 0", bus.o_err_cnt); else passed++;
    total++; if (bus.o_word_cnt !== 32'd0) $display("FAIL clr_word_cnt got %0d want 0", bus.o_word_cnt); else passed++;
    total++; if (bus.o_locked !== 1'b1) $display("FAIL clr_keeps_lock got %0b want 1", bus.o_locked); else passed++;
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, gen ^ 8'h10, 1'b0);
      gen = ref_next(gen);
      if (k == 3) begin
        total++; if (bus.o_locked !== 1'b1) $display("FAIL unlock_early got %0b want 1", bus.o_locked); else passed++;
      end
    end
    total++; if (bus.o_err_cnt !== 32'd4) $display("FAIL unlock_err_cnt got %0d want 4", bus.o_err_cnt); else passed++;
    total++; if (bus.o_locked !== 1'b0) $display("FAIL unlock_locked got %0b want 0", bus.o_locked); else passed++;
    test_lock_at("relock", 9);
  endtask

  task automatic test_clr();
    cyc(1'b1, gen ^ 8'h01, 1'b1);
    gen = ref_next(gen);
    total++; if (bus.o_err !== 1'b1) $display("FAIL clr_same_err got %0b want 1", bus.o_err); else passed++;
    total++; if (bus.o_err_cnt !== 32'd0) $display("FAIL clr_same_err_cnt got %0d want 0", bus.o_err_cnt); else passed++;
    total++; if (bus.o_word_cnt !== 32'd0) $display("FAIL clr_same_word_cnt got %0d want 0", bus.o_word_cnt); else passed++;
  endtask

  task automatic test_hunt_verify();
    logic [7:0] c;
    bit err_seen;
    do_reset();
    cyc(1'b1, 8'hFF, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    gen = 8'h01;
    test_lock_at("hunt_ff", 9);

    do_reset();
    gen = 8'($urandom_range(0, 254));
    err_seen = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, gen, 1'b0);
      gen = ref_next(gen);
      err_seen |= bus.o_err;
    end
    c = gen ^ 8'h01;
    if (c == 8'hFF) c = gen ^ 8'h02;
    cyc(1'b1, c, 1'b0);
    err_seen |= bus.o_err;
    gen = ref_next(c);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, gen, 1'b0);
      gen = ref_next(gen);
      if (k < 9) err_seen |= bus.o_err;
      if (k == 8) begin
        total++; if (bus.o_locked !== 1'b0) $display("FAIL verify_fail_not_seed got %0b want 0", bus.o_locked); else passed++;
      end
    end
    total++; if (bus.o_locked !== 1'b1) $display("FAIL verify_relock got %0b want 1", bus.o_locked); else passed++;
    total++; if (err_seen !== 1'b0) $display("FAIL verify_no_err got %0b want 0", err_seen); else passed++;
    total++; if (bus.o_err_cnt !== 32'd0) $display("FAIL verify_err_cnt got %0d want 0", bus.o_err_cnt); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic c;
    int burst = 0;
    do_reset();
    gen = 8'($urandom_range(0, 254));
    for (int n = 0; n < 400; n++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        cyc(1'b0, 8'($urandom), 1'b0);
        total++; if (bus.o_err !== 1'b0) $display("FAIL rand_idle_err got %0b want 0", bus.o_err); else passed++;
      end
      d = gen;
      if (burst > 0) begin d = gen ^ 8'h80; burst--; end
      else if ($urandom_range(0, 99) < 2) begin burst = 3; d = gen ^ 8'h80; end
      else if ($urandom_range(0, 99) < 8) d = gen ^ 8'(1 << $urandom_range(0, 7));
      else if ($urandom_range(0, 99) < 2) d = 8'($urandom);
      c = ($urandom_range(0, 99) < 2);
      cyc(1'b1, d, c);
      gen = ref_next(gen);
      total++; if (bus.o_locked !== m_locked) $display("FAIL rand_locked n=%0d got %0b want %0b", n, bus.o_locked, m_locked); else passed++;
      total++; if (bus.o_err !== m_err) $display("FAIL rand_err n=%0d got %0b want %0b", n, bus.o_err, m_err); else passed++;
      total++; if (bus.o_err_cnt !== m_errc) $display("FAIL rand_err_cnt n=%0d got %0d want %0d", n, bus.o_err_cnt, m_errc); else passed++;
      total++; if (bus.o_word_cnt !== m_word) $display("FAIL rand_word_cnt n=%0d got %0d want %0d", n, bus.o_word_cnt, m_word); else passed++;
    end
  endtask

  task automatic test_saturate();
    logic [7:0] g4 = 8'h01;
    for (int k = 0; k < 9; k++) begin cyc4(1'b1, g4); g4 = ref_next(g4); end
    total++; if (bus4.o_locked !== 1'b1) $display("FAIL sat_lock got %0b want 1", bus4.o_locked); else passed++;
    for (int e = 1; e <= 20; e++) begin
      cyc4(1'b1, g4 ^ 8'h04); g4 = ref_next(g4);
      if (e == 14) begin
        total++; if (bus4.o_err_cnt !== 4'hE) $display("FAIL sat_err_cnt_14 got %0h want e", bus4.o_err_cnt); else passed++;
      end
      cyc4(1'b1, g4); g4 = ref_next(g4);
    end
    total++; if (bus4.o_err_cnt !== 4'hF) $display("FAIL sat_err_cnt got %0h want f", bus4.o_err_cnt); else passed++;
    total++; if (bus4.o_word_cnt !== 4'hF) $display("FAIL sat_word_cnt got %0h want f", bus4.o_word_cnt); else passed++;
    total++; if (bus4.o_locked !== 1'b1) $display("FAIL sat_locked got %0b want 1", bus4.o_locked); else passed++;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 10; k++) begin cyc(1'b1, gen, 1'b0); gen = ref_next(gen); end
    total++; if (bus.o_locked !== 1'b1) $display("FAIL areset_pre_lock got %0b want 1", bus.o_locked); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.o_locked !== 1'b0) $display("FAIL areset_locked got %0b want 0", bus.o_locked); else passed++;
    total++; if (bus.o_word_cnt !== 32'd0) $display("FAIL areset_word_cnt got %0d want 0", bus.o_word_cnt); else passed++;
    total++; if (bus4.o_locked !== 1'b0) $display("FAIL areset4_locked got %0b want 0", bus4.o_locked); else passed++;
    total++; if (bus4.o_err_cnt !== 4'h0) $display("FAIL areset4_err_cnt got %0h want 0", bus4.o_err_cnt); else passed++;
    total++; if (bus4.o_word_cnt !== 4'h0) $display("FAIL areset4_word_cnt got %0h want 0", bus4.o_word_cnt); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    test_lock_at("areset_relock", 9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_clr();
    test_hunt_verify();
    test_random();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter DW, default 8: LFSR width; supported values 3..35, 128 and 168.
REQ-002 Parameter LOCK_CNT, default 8: consecutive predicted matches needed to declare lock.
REQ-003 Parameter UNLOCK_CNT, default 4: consecutive mismatches in lock needed to drop lock.
REQ-004 Parameter CNT_W, default 32: width of the error and word counters.
REQ-005 i_sysclk  in  1: the single clock; all state changes on its rising edge.
REQ-006 i_areset  in  1: reset, asynchronous and active-high.
REQ-007 i_valid  in  1: i_data is a valid received word this cycle.
REQ-008 i_data  in  DW: received LFSR word; consecutive valid words advance the sequence by one shift step.
REQ-009 i_clr  in  1: synchronous clear of o_err_cnt and o_word_cnt.
REQ-010 o_locked  out  1: checker is in LOCKED.
REQ-011 o_err  out  1: one-cycle pulse, a mismatch was detected while LOCKED.
REQ-012 o_err_cnt  out  CNT_W: saturating count of mismatches detected while LOCKED.
REQ-013 o_word_cnt  out  CNT_W: saturating count of valid words checked while LOCKED.

Function
REQ-014 The next-word function SHALL be next(w) = {w[DW-2:0], fb}, where fb is the left-to-right XNOR chain of w[tap-1] over the XAPP_052 tap set for DW.
REQ-015 The tap set for DW=8 SHALL be 8,6,5,4; the tap set for DW=4 SHALL be 4,3.
REQ-016 FSM states SHALL be HUNT, VERIFY and LOCKED; the reset state is HUNT.
REQ-017 All state changes SHALL happen only on cycles with i_valid=1; with i_valid=0 all state, the model register and counters hold, and o_err=0.
REQ-018 HUNT: on a valid word other than all-ones, the model register SHALL load i_data, the match count SHALL clear, and the FSM SHALL go to VERIFY.
REQ-019 HUNT: an all-ones word (XNOR lockup) SHALL be ignored and the FSM stays in HUNT.
REQ-020 VERIFY, i_data == next(model): the model SHALL load i_data and the match count SHALL increment.
REQ-021 VERIFY: reaching LOCK_CNT matches SHALL move the FSM to LOCKED.
REQ-022 VERIFY, mismatch: the FSM SHALL return to HUNT; the failing word is not used as a seed.
REQ-023 LOCKED: the model SHALL load next(model), not i_data, so a corrupted word does not propagate.
REQ-024 LOCKED: each valid word SHALL increment o_word_cnt.
REQ-025 LOCKED, i_data != next(model): o_err pulses, o_err_cnt increments and the miss count increments.
REQ-026 LOCKED, match: the miss count SHALL clear.
REQ-027 LOCKED: reaching UNLOCK_CNT consecutive misses SHALL move the FSM to HUNT and deassert o_locked.
REQ-028 Latency: o_err, o_locked and the counters SHALL update on the clock edge that samples the valid word (registered, 1 cycle).
REQ-029 o_err_cnt and o_word_cnt SHALL saturate at all-ones and not wrap.
REQ-030 i_clr SHALL zero both counters on the next edge; i_clr takes priority over a same-cycle increment.
REQ-031 i_clr SHALL NOT affect the FSM state, the model register or o_locked.

Reset
REQ-032 On i_areset: FSM = HUNT, model = 0, match and miss counts = 0, o_locked = 0, o_err = 0, o_err_cnt = 0, o_word_cnt = 0.
REQ-033 Reset asserted mid-lock SHALL take effect immediately (asynchronously); after release, relock requires a fresh HUNT/VERIFY pass.

Structure
REQ-034 A shared package lfsr_pkg SHALL hold the DW-indexed tap table (tap count plus up to four tap positions) and the FSM state enum.
REQ-035 One sub-module, lfsr_next (purely combinational, parameter DW, word in / next word out), SHALL implement REQ-014 and be reusable by the generator side.

Verification
REQ-036 Reset, then 8'h01, 8'h03, and further next() words for 9 valid words total -> o_locked=1 on the edge after the 9th word; o_err_cnt=0.
REQ-037 Locked, one word with bit 0 flipped -> one o_err pulse, o_err_cnt=1, o_locked stays 1, and the following correct words give no further errors.
REQ-038 Locked, 4 consecutive corrupted words -> o_err_cnt=4, o_locked=0, FSM in HUNT; a clean stream relocks after 9 words.
REQ-039 In HUNT, 8'hFF then idle -> FSM stays in HUNT; in VERIFY, a mismatch at match 5 -> FSM returns to HUNT, o_err never pulses.
REQ-040 i_clr asserted in the same cycle as a locked error -> both counters read 0; with i_valid gaps of 0..3 cycles inserted, lock and error counts are unchanged.
REQ-041 Force o_err_cnt near all-ones (CNT_W=4): 20 errors -> o_err_cnt=4'hF; assert i_areset while locked -> all outputs 0 asynchronously.
